pid_seq_ctrl: RTL and testbench
===============================

Name: pid_seq_ctrl

Overview:
- Control-path sequencer for the PID datapath.
- Each sample tick triggers a fixed sequence of load-enable strobes to the datapath's enable registers (error, integrator, accumulator, previous-error, output).
- Drives the select of the single shared multiplier through the P, I and D products.
- Produces no data itself; only enables, mux selects and status.

Parameters:
- MUL_LAT, 2, shared-multiplier latency in cycles from operand select to valid product; legal range 1..15.
- CNT_W, 4, width of the internal latency counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- run  in  1  controller enable; ticks are ignored while low
- sample_tick  in  1  one-cycle pulse requesting a new PID computation
- ovr_clr  in  1  clears the sticky overrun flag
- en_err  out  1  load strobe, error register
- en_integ  out  1  load strobe, integrator register
- acc_clr  out  1  synchronous clear of the accumulator register
- en_acc  out  1  load strobe, accumulator (acc += product)
- en_prev  out  1  load strobe, previous-error register
- en_out  out  1  load strobe, output register
- mul_sel  out  2  shared multiplier operand select: 0 = Kp*err, 1 = Ki*integ, 2 = Kd*(err-prev), 3 = unused
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, coincident with en_out
- overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE; latency counter = 0; overrun = 0.
  - All strobes 0, mul_sel = 0, busy = 0, done = 0.
  - Applies mid-sequence as well: the sequence is abandoned and no done pulse is issued.
- FSM states: IDLE, LOAD, INTEG, MUL_P, MUL_I, MUL_D, UPDATE. State is registered; outputs are decoded from the state register and counter only (Moore).
- IDLE: if run=1 and sample_tick=1, go to LOAD next cycle; otherwise stay.
- LOAD, one cycle: en_err=1, acc_clr=1. Next state INTEG.
- INTEG, one cycle: en_integ=1 (integ += err). Next state MUL_P.
- MUL_P, MUL_I, MUL_D, each exactly MUL_LAT cycles:
  - mul_sel = 0 / 1 / 2 respectively, held for the whole state.
  - Counter loads 0 on entry and increments each cycle.
  - en_acc=1 only in the cycle where counter == MUL_LAT-1; the state advances after that cycle.
  - Order is MUL_P -> MUL_I -> MUL_D -> UPDATE.
- UPDATE, one cycle: en_prev=1, en_out=1, done=1. Next state IDLE.
- Latency: tick sampled at edge N; LOAD occupies cycle N+1; done is high in cycle N+3+3*MUL_LAT (N+9 for MUL_LAT=2). Full sequence length is 3+3*MUL_LAT cycles.
- Back-to-back: a tick in the same cycle the FSM is in IDLE after UPDATE is accepted. Minimum tick period is 4+3*MUL_LAT cycles without overrun.
- Overrun:
  - sample_tick=1 while busy=1 sets overrun on the next edge.
  - The tick is dropped: it is not queued, and the running sequence is unaffected.
  - ovr_clr=1 clears overrun. If ovr_clr and a set condition occur in the same cycle, set wins.
- run deasserted mid-sequence: the sequence completes normally; only new ticks are gated.
- At most one strobe among en_err, en_integ, en_acc, en_prev/en_out is high in any cycle. en_prev and en_out pulse together.

Optional Feature:
- Macro: PID_SEQ_DERIV_EN.
- Defined: full PID sequence as above. mul_sel=2 is used; sequence length is 3+3*MUL_LAT.
- Undefined: MUL_D state is not built and MUL_I goes directly to UPDATE. mul_sel never equals 2. en_prev is tied to 0. Sequence length is 3+2*MUL_LAT; done occurs at cycle N+3+2*MUL_LAT.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with sample_tick=1 and run=1 -> all outputs 0, busy=0, overrun=0; the first edge after release with tick=1 enters LOAD.
- Single sequence, MUL_LAT=2, DERIV_EN defined, tick at cycle 0:
  - en_err and acc_clr in cycle 1; en_integ in cycle 2.
  - mul_sel=0 in cycles 3-4, =1 in cycles 5-6, =2 in cycles 7-8.
  - en_acc in cycles 4, 6 and 8.
  - en_prev, en_out and done in cycle 9; busy low again in cycle 10.
- Overrun: tick at cycle 0 and again at cycle 4 -> overrun=1 from cycle 5, done still only in cycle 9. ovr_clr in cycle 12 -> overrun=0 in cycle 13.
- Gating: run=0 and tick -> stays IDLE. run dropped in cycle 3 of an active sequence -> done still in cycle 9.
- Mid-reset: tick at cycle 0, rst=1 in cycle 6 -> IDLE in cycle 7, all strobes 0, no done pulse.
- MUL_LAT=1 and DERIV_EN undefined, tick at cycle 0 -> en_acc in cycles 3 and 4, mul_sel never 2, done in cycle 5, en_prev never asserted.

Source files
------------

// File: rtl/pid_seq_ctrl.sv
// Control-path sequencer for the PID datapath: turns each sample tick into load strobes and multiplier selects.
// Define PID_SEQ_DERIV_EN to build the derivative (MUL_D) step; without it the sequence is P, I only.
module pid_seq_ctrl #(
  parameter int MUL_LAT = 2,  // 1..15
  parameter int CNT_W   = 4   // 2**CNT_W > MUL_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       sample_tick,
  input  logic       ovr_clr,
  output logic       en_err,
  output logic       en_integ,
  output logic       acc_clr,
  output logic       en_acc,
  output logic       en_prev,
  output logic       en_out,
  output logic [1:0] mul_sel,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INTEG,
    MUL_P,
    MUL_I,
`ifdef PID_SEQ_DERIV_EN
    MUL_D,
`endif
    UPDATE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             mul_last;

  // NOTE: state holds with <= so every flop samples the pre-edge value; reset is synchronous, inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mul_last = (cnt_q == LAST_CNT);

  // NOTE: every always_comb output gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ovr_d   = ovr_q;

    // A tick that arrives while a sequence is running is dropped and flagged; set beats clear.
    if (sample_tick && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE:   if (run && sample_tick) state_d = LOAD;
      LOAD:   state_d = INTEG;
      INTEG:  state_d = MUL_P;
      MUL_P: begin
        if (mul_last) state_d = MUL_I;
        else          cnt_d   = cnt_q + 1'b1;
      end
      MUL_I: begin
`ifdef PID_SEQ_DERIV_EN
        if (mul_last) state_d = MUL_D;
`else
        if (mul_last) state_d = UPDATE;
`endif
        else          cnt_d   = cnt_q + 1'b1;
      end
`ifdef PID_SEQ_DERIV_EN
      MUL_D: begin
        if (mul_last) state_d = UPDATE;
        else          cnt_d   = cnt_q + 1'b1;
      end
`endif
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: decoded from the state register and counter only.
  always_comb begin
    en_err   = 1'b0;
    en_integ = 1'b0;
    acc_clr  = 1'b0;
    en_acc   = 1'b0;
    en_prev  = 1'b0;
    en_out   = 1'b0;
    mul_sel  = 2'd0;
    done     = 1'b0;

    unique case (state_q)
      LOAD: begin
        en_err  = 1'b1;
        acc_clr = 1'b1;
      end
      INTEG: en_integ = 1'b1;
      MUL_P: begin
        mul_sel = 2'd0;
        en_acc  = mul_last;
      end
      MUL_I: begin
        mul_sel = 2'd1;
        en_acc  = mul_last;
      end
`ifdef PID_SEQ_DERIV_EN
      MUL_D: begin
        mul_sel = 2'd2;
        en_acc  = mul_last;
      end
`endif
      UPDATE: begin
`ifdef PID_SEQ_DERIV_EN
        en_prev = 1'b1;
`endif
        en_out  = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_pid_seq_ctrl.sv
// Scoreboard bench for pid_seq_ctrl: a sequence-offset reference model predicts every cycle's outputs
// and every done pulse; a negedge monitor pops and compares.
module tb_pid_seq_ctrl;

  localparam int MUL_LAT = 2;
  localparam int CNT_W   = 4;
`ifdef PID_SEQ_DERIV_EN
  localparam int N_MUL = 3;
  localparam bit HAS_D = 1'b1;
`else
  localparam int N_MUL = 2;
  localparam bit HAS_D = 1'b0;
`endif
  localparam int SEQ_LEN = 3 + N_MUL * MUL_LAT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b1;
  logic       sample_tick = 1'b1;
  logic       ovr_clr = 1'b0;
  logic       en_err, en_integ, acc_clr, en_acc, en_prev, en_out;
  logic [1:0] mul_sel;
  logic       busy, done, overrun;

  pid_seq_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .run(run), .sample_tick(sample_tick), .ovr_clr(ovr_clr),
    .en_err(en_err), .en_integ(en_integ), .acc_clr(acc_clr), .en_acc(en_acc),
    .en_prev(en_prev), .en_out(en_out), .mul_sel(mul_sel),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en_err;
    logic       en_integ;
    logic       acc_clr;
    logic       en_acc;
    logic       en_prev;
    logic       en_out;
    logic [1:0] mul_sel;
    logic       busy;
    logic       done;
    logic       overrun;
  } outs_t;

  outs_t exp_q[$];
  int    done_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  // Reference model: a running sequence is just its start cycle; outputs follow from the offset into it.
  bit m_active = 1'b0;
  int m_start  = 0;
  bit m_ovr    = 1'b0;

  function automatic outs_t model_outs(input int t);
    outs_t o;
    int    off;
    o   = '0;
    off = t - m_start;
    o.overrun = m_ovr;
    if (m_active && off >= 0 && off < SEQ_LEN) begin
      o.busy = 1'b1;
      if (off == 0) begin
        o.en_err  = 1'b1;
        o.acc_clr = 1'b1;
      end else if (off == 1) begin
        o.en_integ = 1'b1;
      end else if (off == SEQ_LEN - 1) begin
        o.en_prev = HAS_D;
        o.en_out  = 1'b1;
        o.done    = 1'b1;
      end else begin
        o.mul_sel = 2'((off - 2) / MUL_LAT);
        o.en_acc  = ((off - 2) % MUL_LAT) == MUL_LAT - 1;
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc - 1);
    end
  endtask

  // One clock cycle: record the prediction for this cycle, drive its inputs, advance the model.
  task automatic step(input bit r, input bit rn, input bit tk, input bit cl);
    outs_t now;
    @(posedge clk);
    #1;
    now = model_outs(cyc);
    exp_q.push_back(now);
    rst         = r;
    run         = rn;
    sample_tick = tk;
    ovr_clr     = cl;
    if (r) begin
      m_active = 1'b0;
      m_ovr    = 1'b0;
      while (done_q.size() > 0 && done_q[$] > cyc) void'(done_q.pop_back());
    end else begin
      if (tk && now.busy) m_ovr = 1'b1;
      else if (cl)        m_ovr = 1'b0;
      if (!now.busy && rn && tk) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
        done_q.push_back(cyc + SEQ_LEN);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    outs_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {en_err, en_integ, acc_clr, en_acc, en_prev, en_out, mul_sel, busy, done, overrun};
      check("outputs", 32'(g), 32'(e));
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL done_unexpected: done=1 at cycle %0d, none pending", cyc - 1);
        end else begin
          check("done_cycle", 32'(cyc - 1), 32'(done_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // Reset held with tick and run high, then release with a tick.
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(SEQ_LEN + 2);

    // Overrun: second tick mid-sequence, later cleared.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(7);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Tick during UPDATE is dropped; tick in the following IDLE is accepted.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(SEQ_LEN - 1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(SEQ_LEN + 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Set and clear together: set wins.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(SEQ_LEN);
    step(1'b0, 1'b1, 1'b0, 1'b1);

    // Gating: tick with run low ignored; run dropped mid-sequence still completes.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    repeat (SEQ_LEN) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-sequence reset: no done pulse.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(SEQ_LEN);

    // Randomized traffic.
    repeat (800) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end
    idle(SEQ_LEN + 2);

    @(negedge clk);
    #1;
    if (done_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_missing: %0d expected done pulses never seen, first due cycle %0d",
               done_q.size(), done_q[0]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
